// File: rtl/retire_ctrl_pkg.sv
// Shared machine definitions for the retirement stage: ROB entry layout,
// retire FSM states and the filter's event classification.
`ifndef SYS_DEFS_MACROS
`define SYS_DEFS_MACROS
`define XLEN 32
`define ROB 32
`define SD
`endif

package retire_ctrl_pkg;

   localparam int unsigned XLEN = `XLEN;

   typedef struct packed {
      logic              valid;
      logic              precise_state_need;
      logic [`XLEN-1:0]  target_pc;
      logic              halt;
      logic              is_store;
   } ROB_ENTRY_PACKET;

   typedef enum logic [1:0] {
      NORMAL,
      RECOVER,
      HALTED
   } RETIRE_STATE;

   typedef enum logic [1:0] {
      EVT_NONE,
      EVT_RECOVER,
      EVT_HALT
   } RETIRE_EVENT;

   function automatic logic [1:0] popcount3(input logic [2:0] m);
      return 2'(m[0]) + 2'(m[1]) + 2'(m[2]);
   endfunction

endpackage

// File: rtl/retire_ctrl_if.sv
// Retire-stage bus between the ROB (slave side) and the retirement sequencer.
interface retire_ctrl_if
   import retire_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 64
);
   ROB_ENTRY_PACKET [2:0] retire_entry;
   logic [2:0]            commit_valid;
   logic [2:0]            store_commit;
   logic                  BPRecoverEN;
   logic [XLEN-1:0]       recover_pc;
   logic                  fetch_stall;
   logic                  halted;
   logic [CNT_W-1:0]      retire_count;

   modport master (
      input  retire_entry,
      output commit_valid, store_commit, BPRecoverEN, recover_pc,
             fetch_stall, halted, retire_count
   );

   modport slave (
      output retire_entry,
      input  commit_valid, store_commit, BPRecoverEN, recover_pc,
             fetch_stall, halted, retire_count
   );
endinterface

// File: rtl/retire_filter.sv
// Program-order scan of the retire group (slot 2 oldest): commit mask cut at
// the first invalid slot or the first halt/mispredict, plus the event found.
module retire_filter
   import retire_ctrl_pkg::*;
(
   input  ROB_ENTRY_PACKET [2:0] retire_entry,
   output logic [2:0]            commit_valid,
   output logic [2:0]            store_commit,
   output RETIRE_EVENT           event_type,
   output logic [XLEN-1:0]       event_pc,
   output logic [1:0]            commit_cnt
);
   logic scan;

   always_comb begin
      commit_valid = '0;
      store_commit = '0;
      event_type   = EVT_NONE;
      event_pc     = '0;
      scan         = 1'b1;
      for (int unsigned k = 0; k < 3; k++) begin
         // k walks oldest-first, so slot index is 2-k
         if (scan) begin
            if (!retire_entry[2-k].valid) begin
               scan = 1'b0;
            end else begin
               commit_valid[2-k] = 1'b1;
               store_commit[2-k] = retire_entry[2-k].is_store;
               if (retire_entry[2-k].halt) begin
                  event_type = EVT_HALT;
                  scan       = 1'b0;
               end else if (retire_entry[2-k].precise_state_need) begin
                  event_type = EVT_RECOVER;
                  event_pc   = retire_entry[2-k].target_pc;
                  scan       = 1'b0;
               end
            end
         end
      end
      commit_cnt = popcount3(commit_valid);
   end
endmodule

// File: rtl/retire_ctrl.sv
// Retirement sequencer: FSM for recovery window and halt, plus the
// architectural retired-instruction counter.
module retire_ctrl
   import retire_ctrl_pkg::*;
#(
   parameter int unsigned RECOVER_CYCLES = 2,
   parameter int unsigned CNT_W          = 64
)(
   input  logic          clock,
   input  logic          reset,
   retire_ctrl_if.master bus
);
   RETIRE_STATE       state;
   logic [3:0]        rec_cnt;
   logic [CNT_W-1:0]  count_r;
   logic              fetch_stall_r;
   logic              halted_r;

   logic [2:0]        f_commit;
   logic [2:0]        f_store;
   RETIRE_EVENT       f_event;
   logic [XLEN-1:0]   f_pc;
   logic [1:0]        f_cnt;
   logic              active;

   retire_filter u_filter (
      .retire_entry (bus.retire_entry),
      .commit_valid (f_commit),
      .store_commit (f_store),
      .event_type   (f_event),
      .event_pc     (f_pc),
      .commit_cnt   (f_cnt)
   );

   assign active = (state == NORMAL);

   always_comb begin
      bus.commit_valid = active ? f_commit : '0;
      bus.store_commit = active ? f_store  : '0;
      bus.BPRecoverEN  = active && (f_event == EVT_RECOVER);
      bus.recover_pc   = (active && (f_event == EVT_RECOVER)) ? f_pc : '0;
      bus.fetch_stall  = fetch_stall_r;
      bus.halted       = halted_r;
      bus.retire_count = count_r;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= NORMAL;
         rec_cnt       <= '0;
         count_r       <= '0;
         fetch_stall_r <= 1'b0;
         halted_r      <= 1'b0;
      end else begin
         count_r <= count_r + CNT_W'(active ? f_cnt : 2'd0);
         unique case (state)
            NORMAL: begin
               if (f_event == EVT_HALT) begin
                  state         <= HALTED;
                  fetch_stall_r <= 1'b1;
                  halted_r      <= 1'b1;
               end else if (f_event == EVT_RECOVER) begin
                  state         <= RECOVER;
                  rec_cnt       <= 4'(RECOVER_CYCLES);
                  fetch_stall_r <= 1'b1;
               end
            end
            RECOVER: begin
               rec_cnt <= rec_cnt - 4'd1;
               if (rec_cnt == 4'd1) begin
                  state         <= NORMAL;
                  fetch_stall_r <= 1'b0;
               end
            end
            HALTED: begin
               state <= HALTED;
            end
            default: begin
               state <= NORMAL;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_retire_ctrl.sv
// Directed bench for retire_ctrl: one instance with the default 2-cycle
// recovery window, one with a 5-cycle window.
module tb_retire_ctrl;
   import retire_ctrl_pkg::*;

   logic clock = 1'b0;
   logic reset_a, reset_b;
   int   total = 0;
   int   bad   = 0;

   always #5 clock = ~clock;

   retire_ctrl_if #(.CNT_W(64)) bus_a ();
   retire_ctrl_if #(.CNT_W(64)) bus_b ();

   retire_ctrl #(.RECOVER_CYCLES(2), .CNT_W(64)) dut_a (
      .clock (clock), .reset (reset_a), .bus (bus_a));
   retire_ctrl #(.RECOVER_CYCLES(5), .CNT_W(64)) dut_b (
      .clock (clock), .reset (reset_b), .bus (bus_b));

   function automatic ROB_ENTRY_PACKET ent(input logic v, input logic p,
                                           input logic h, input logic s,
                                           input logic [XLEN-1:0] pc);
      ROB_ENTRY_PACKET e;
      e.valid = v; e.precise_state_need = p; e.halt = h; e.is_store = s;
      e.target_pc = pc;
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_a(input ROB_ENTRY_PACKET e2, input ROB_ENTRY_PACKET e1,
                        input ROB_ENTRY_PACKET e0);
      bus_a.retire_entry[2] = e2;
      bus_a.retire_entry[1] = e1;
      bus_a.retire_entry[0] = e0;
      #1;
   endtask

   task automatic set_b(input ROB_ENTRY_PACKET e2, input ROB_ENTRY_PACKET e1,
                        input ROB_ENTRY_PACKET e0);
      bus_b.retire_entry[2] = e2;
      bus_b.retire_entry[1] = e1;
      bus_b.retire_entry[0] = e0;
      #1;
   endtask

   ROB_ENTRY_PACKET nul, pln;

   initial begin
      nul = ent(0, 0, 0, 0, '0);
      pln = ent(1, 0, 0, 0, '0);
      reset_a = 1'b1;
      reset_b = 1'b1;
      set_a(nul, nul, nul);
      set_b(nul, nul, nul);
      step();
      step();
      reset_a = 1'b0;
      reset_b = 1'b0;

      // reset state
      check("rst_stall",  64'(bus_a.fetch_stall),  0);
      check("rst_halted", 64'(bus_a.halted),       0);
      check("rst_count",  bus_a.retire_count,      0);
      check("rst_bp",     64'(bus_a.BPRecoverEN),  0);
      check("rst_pc",     64'(bus_a.recover_pc),   0);
      check("rst_commit", 64'(bus_a.commit_valid), 0);

      // plain retirement, 4 full groups
      set_a(pln, pln, pln);
      for (int i = 0; i < 4; i++) begin
         check("plain_commit", 64'(bus_a.commit_valid), 64'b111);
         check("plain_bp",     64'(bus_a.BPRecoverEN),  0);
         step();
      end
      check("plain_count", bus_a.retire_count, 12);

      // store release
      set_a(ent(1, 0, 0, 1, '0), pln, ent(1, 0, 0, 1, '0));
      check("store_mask", 64'(bus_a.store_commit), 64'b101);
      step();
      check("store_count", bus_a.retire_count, 15);

      // mispredict in middle slot
      set_a(ent(1, 0, 0, 1, '0), ent(1, 1, 0, 0, 32'h40), pln);
      check("mp_commit", 64'(bus_a.commit_valid), 64'b110);
      check("mp_store",  64'(bus_a.store_commit), 64'b100);
      check("mp_bp",     64'(bus_a.BPRecoverEN),  1);
      check("mp_pc",     64'(bus_a.recover_pc),   64'h40);
      step();
      set_a(ent(1, 0, 0, 1, '0), ent(1, 0, 0, 1, '0), ent(1, 0, 0, 1, '0));
      check("rec1_stall",  64'(bus_a.fetch_stall),  1);
      check("rec1_count",  bus_a.retire_count,      17);
      check("rec1_commit", 64'(bus_a.commit_valid), 0);
      check("rec1_store",  64'(bus_a.store_commit), 0);
      check("rec1_bp",     64'(bus_a.BPRecoverEN),  0);
      check("rec1_pc",     64'(bus_a.recover_pc),   0);
      step();
      check("rec2_stall",  64'(bus_a.fetch_stall),  1);
      check("rec2_commit", 64'(bus_a.commit_valid), 0);
      step();
      check("rec3_stall",  64'(bus_a.fetch_stall),  0);
      check("rec3_commit", 64'(bus_a.commit_valid), 64'b111);
      check("rec3_count",  bus_a.retire_count,      17);
      step();
      check("post_count",  bus_a.retire_count,      20);

      // valid after invalid is ignored
      set_a(pln, nul, pln);
      check("gap_commit", 64'(bus_a.commit_valid), 64'b100);
      step();
      set_a(nul, pln, pln);
      check("hole_commit", 64'(bus_a.commit_valid), 0);
      step();
      check("gap_count", bus_a.retire_count, 21);

      // oldest event wins: mispredict in slot 2, halt in slot 0
      set_a(ent(1, 1, 0, 0, 32'h1234), pln, ent(1, 0, 1, 0, '0));
      check("two_commit", 64'(bus_a.commit_valid), 64'b100);
      check("two_bp",     64'(bus_a.BPRecoverEN),  1);
      check("two_pc",     64'(bus_a.recover_pc),   64'h1234);
      step();
      set_a(nul, nul, nul);
      check("two_halted", 64'(bus_a.halted),      0);
      check("two_stall",  64'(bus_a.fetch_stall), 1);
      step();
      step();
      check("two_resume", 64'(bus_a.fetch_stall), 0);
      check("two_count",  bus_a.retire_count,     22);

      // halt beats mispredict in the same slot
      set_a(pln, ent(1, 1, 1, 0, 32'h80), pln);
      check("halt_commit", 64'(bus_a.commit_valid), 64'b110);
      check("halt_bp",     64'(bus_a.BPRecoverEN),  0);
      check("halt_pc",     64'(bus_a.recover_pc),   0);
      step();
      set_a(ent(1, 1, 0, 1, 32'h99), pln, pln);
      check("halt_flag",   64'(bus_a.halted),       1);
      check("halt_stall",  64'(bus_a.fetch_stall),  1);
      check("halt_count",  bus_a.retire_count,      24);
      for (int i = 0; i < 3; i++) begin
         check("hlt_commit", 64'(bus_a.commit_valid), 0);
         check("hlt_bp",     64'(bus_a.BPRecoverEN),  0);
         step();
      end
      check("hlt_frozen", bus_a.retire_count, 24);
      check("hlt_sticky", 64'(bus_a.halted),  1);

      // reset out of HALTED overrides a same-cycle halt
      reset_a = 1'b1;
      set_a(ent(1, 0, 1, 0, '0), pln, pln);
      step();
      reset_a = 1'b0;
      set_a(nul, nul, nul);
      check("rsth_halted", 64'(bus_a.halted),      0);
      check("rsth_stall",  64'(bus_a.fetch_stall), 0);
      check("rsth_count",  bus_a.retire_count,     0);

      // 5-cycle recovery window
      set_b(ent(1, 1, 0, 0, 32'h200), pln, pln);
      check("b_bp", 64'(bus_b.BPRecoverEN), 1);
      step();
      set_b(pln, pln, pln);
      for (int i = 0; i < 5; i++) begin
         check("b_stall",  64'(bus_b.fetch_stall),  1);
         check("b_commit", 64'(bus_b.commit_valid), 0);
         step();
      end
      check("b_resume", 64'(bus_b.fetch_stall),  0);
      check("b_commit_resume", 64'(bus_b.commit_valid), 64'b111);
      step();
      set_b(nul, nul, nul);
      check("b_count", bus_b.retire_count, 4);

      // reset mid-RECOVER
      set_b(ent(1, 1, 0, 0, 32'h300), nul, nul);
      check("b2_bp", 64'(bus_b.BPRecoverEN), 1);
      step();
      set_b(nul, nul, nul);
      check("b2_stall", 64'(bus_b.fetch_stall), 1);
      reset_b = 1'b1;
      step();
      reset_b = 1'b0;
      set_b(pln, pln, pln);
      check("b2_rst_stall",  64'(bus_b.fetch_stall),  0);
      check("b2_rst_count",  bus_b.retire_count,      0);
      check("b2_rst_commit", 64'(bus_b.commit_valid), 64'b111);
      step();
      check("b2_count", bus_b.retire_count, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/retire_ctrl.md
# retire_ctrl

Retirement sequencer between the reorder buffer's three retire slots and the rest of the machine. Each cycle it filters the retiring group in program order and cuts it at the first halt or mispredicted branch. It drives the branch-recovery pulse (`BPRecoverEN`) and the redirect PC, holds fetch off for a fixed recovery window, latches the halt state, and keeps the architectural retired-instruction count.

## Interface
Parameters:
- RECOVER_CYCLES, 2, number of cycles `fetch_stall` stays high after a recovery pulse (legal range 1..15).
- CNT_W, 64, width of `retire_count`.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- retire_entry  in  ROB_ENTRY_PACKET[2:0]  retiring group; slot 2 is oldest, slot 0 youngest. Fields used: valid, precise_state_need, target_pc, halt, is_store.
- commit_valid  out  3  per-slot "architecturally committed" mask.
- store_commit  out  3  commit_valid & is_store; release mask to the store queue.
- BPRecoverEN  out  1  one-cycle flush pulse to the ROB, RS, map table and free list.
- recover_pc  out  `XLEN  redirect target; valid only while `BPRecoverEN`=1, else 0.
- fetch_stall  out  1  high during the recovery window and while halted.
- halted  out  1  sticky once a halt commits.
- retire_count  out  CNT_W  committed instruction total.

## Operation
- States: NORMAL, RECOVER, HALTED. Reset to NORMAL, recovery counter = 0, retire_count = 0.
- NORMAL, scan from slot 2 down to slot 0:
  - The scan stops at the first slot that is invalid. A valid slot after an invalid one is treated as a protocol error and is ignored.
  - A valid slot commits (commit_valid=1).
  - If the committed slot has halt=1: all younger slots are masked and the next state is HALTED. Halt wins over precise_state_need in the same slot; no recovery is raised.
  - Else if it has precise_state_need=1: all younger slots are masked, `BPRecoverEN`=1, recover_pc = that slot's target_pc, the counter loads RECOVER_CYCLES and the next state is RECOVER.
  - Only the oldest qualifying event in the group acts.
- RECOVER:
  - commit_valid = 0 and retire_entry is ignored; the ROB is empty after the flush.
  - fetch_stall = 1; the counter decrements each cycle.
  - When counter = 1, the next state is NORMAL.
- HALTED:
  - Terminal until reset.
  - commit_valid = 0, `BPRecoverEN` = 0, fetch_stall = 1, halted = 1.
- retire_count += popcount(commit_valid) every cycle. Addition is modulo 2^CNT_W; wrap is silent.
- The counter is 4 bits wide. RECOVER_CYCLES = 0 is illegal.

## Timing
- commit_valid, store_commit, `BPRecoverEN` and recover_pc are combinational from retire_entry and the current state, in the same cycle as retirement. The ROB samples `BPRecoverEN` at the same edge it retires.
- Mispredict retiring in cycle N:
  - `BPRecoverEN` = 1 in cycle N only.
  - fetch_stall = 1 in cycles N+1 .. N+RECOVER_CYCLES.
  - NORMAL resumes in cycle N+RECOVER_CYCLES+1.
- Halt retiring in cycle N: halted = 1 and fetch_stall = 1 from N+1 onward.
- retire_count reflects cycle N's commits from N+1.
- Reset values: all outputs 0 (fetch_stall 0, halted 0, retire_count 0).
- Reset asserted in any state, including mid-RECOVER or HALTED: next cycle is NORMAL with counter 0 and retire_count 0. Reset overrides a same-cycle mispredict or halt.

## Structure
- The shared sys_defs package carries:
  - ROB_ENTRY_PACKET, which gains halt and is_store fields;
  - the `XLEN, `ROB and `SD macros;
  - a RETIRE_STATE enum {NORMAL, RECOVER, HALTED}.
- One natural sub-module: retire_filter, purely combinational. It takes retire_entry and produces commit_valid, an event-slot index, an event type and a popcount.
- retire_ctrl holds the FSM, the recovery counter and retire_count.

## Test plan
- Normal retirement: NORMAL, 3 valid plain slots for 4 cycles -> commit_valid=111 each cycle, retire_count=12, `BPRecoverEN` never 1.
- Mispredict in the middle slot: slot 1 has precise_state_need=1, target_pc=0x0000_0040, slot 2 plain, slot 0 valid -> commit_valid=110, `BPRecoverEN`=1, recover_pc=0x40 in that cycle; fetch_stall=1 for exactly 2 cycles; retire_count +2.
- Two events in one group: slot 2 mispredicts and slot 0 has halt -> only slot 2 commits, recovery is taken, halted stays 0.
- Halt: slot 2 valid, slot 1 halt=1 and precise_state_need=1 -> commit_valid=110, no recovery pulse, halted=1 next cycle. Later valid groups give commit_valid=000 and a frozen count.
- Store release: slots is_store=101, all valid, no events -> store_commit=101. During RECOVER -> store_commit=000.
- Reset mid-RECOVER: assert reset in cycle N+1 after a mispredict -> cycle N+2 is NORMAL, fetch_stall=0, retire_count=0. With RECOVER_CYCLES=5, check fetch_stall for 5 cycles.
